// File: rtl/word_serializer_pkg.sv
// Shared types and sizing helpers for the word serializer.
package word_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int beats_per_word(input int data_width, input int chunk_width);
    return data_width / chunk_width;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_serializer_beat_counter.sv
// Modulo-N beat counter with enable and synchronous clear; tc flags beat N-1.
module beat_counter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_p0;

  assign tc = (cnt_p0 == LAST);

  // Wrapping on tc returns the count to 0, which is also where a fresh word starts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_p0 <= '0;
    end else if (clr) begin
      cnt_p0 <= '0;
    end else if (en) begin
      cnt_p0 <= tc ? '0 : cnt_p0 + W'(1);
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Word-to-beat serializer, MSB-first, with final-beat flag.
// Define WORD_SERIALIZER_BACK_TO_BACK_EN to accept the next word on the final-beat handshake.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CHUNK_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clrh,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  data_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHUNK_WIDTH-1:0] data_o,
  output logic                   last_o,
  output logic                   busy_o
);

  localparam int N     = beats_per_word(DATA_WIDTH, CHUNK_WIDTH);
  localparam int CNT_W = cnt_width(N);

  if (((DATA_WIDTH % CHUNK_WIDTH) != 0) || (N < 2)) begin : g_param_check
    $error("word_serializer: DATA_WIDTH must be a multiple of CHUNK_WIDTH with at least 2 beats");
  end

  state_t                state_p0, state_d;
  logic [DATA_WIDTH-1:0] shreg_p0, shreg_d;
  logic                  tc;
  logic                  beat_fire;
  logic                  load;

  assign out_valid = (state_p0 == SHIFT);
  assign busy_o    = out_valid;
  assign last_o    = out_valid & tc;
  assign data_o    = shreg_p0[DATA_WIDTH-1 -: CHUNK_WIDTH];
  assign beat_fire = out_valid & out_ready & ~clrh;
  assign load      = in_valid & in_ready;

  always_comb begin
    in_ready = 1'b0;
    if (rstn && !clrh) begin
      if (state_p0 == IDLE) begin
        in_ready = 1'b1;
`ifdef WORD_SERIALIZER_BACK_TO_BACK_EN
      end else if (last_o && out_ready) begin
        in_ready = 1'b1;
`endif
      end
    end
  end

  beat_counter #(
    .N (N),
    .W (CNT_W)
  ) u_beat_counter (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clrh),
    .en   (beat_fire),
    .tc   (tc)
  );

  always_comb begin
    state_d = state_p0;
    shreg_d = shreg_p0;
    if (clrh) begin
      state_d = IDLE;
      shreg_d = '0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (load) begin
            state_d = SHIFT;
            shreg_d = data_i;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (!tc) begin
              shreg_d = shreg_p0 << CHUNK_WIDTH;
            end else if (load) begin
              shreg_d = data_i;
            end else begin
              state_d = IDLE;
              shreg_d = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          shreg_d = '0;
        end
      endcase
    end
  end

  // Stage p0: word/state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_p0 <= IDLE;
      shreg_p0 <= '0;
    end else begin
      state_p0 <= state_d;
      shreg_p0 <= shreg_d;
    end
  end

endmodule
